sixbitsub_serial: RTL

Bit-serial 6-bit subtractor for the calculator datapath. It computes ain − bin one bit per clock, LSB first, using a single full-subtractor cell. Each operation uses a start/busy/done handshake, and the result is presented in registered form. It is the subtract-direction counterpart to the 6-bit combinational adder, for ALU paths where area matters more than latency.

---
 rtl/sixbitsub_serial.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sixbitsub_serial.sv
// sixbitsub_serial: bit-serial 6-bit subtractor (ain - bin mod 64), LSB first,
// one full-subtractor step per clock, with a start/busy/done handshake.
//
// Optional feature macro: SIXBITSUB_SIGNED_EN enables the registered
// two's-complement overflow flag. When it is undefined, ovf is tied to 0.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted in IDLE or DONE
//   ain    in   [5:0] minuend, sampled with an accepted start
//   bin    in   [5:0] subtrahend, sampled with an accepted start
//   diff   out  [5:0] registered result, updated at completion only
//   bout   out  registered borrow out (ain < bin unsigned)
//   ovf    out  signed overflow flag (0 unless SIXBITSUB_SIGNED_EN)
//   busy   out  operation in progress
//   done   out  one-cycle pulse when a new result is presented
module sixbitsub_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] ain,
    input  logic [5:0] bin,
    output logic [5:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    localparam int unsigned W  = 6;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   a_sh, a_sh_n;
    logic [W-1:0]   b_sh, b_sh_n;
    logic [W-1:0]   r_sh, r_sh_n;
    logic           br, br_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [W-1:0]   diff_n;
    logic           bout_n;
    logic           busy_n;
    logic           done_n;

    // Full-subtractor cell on the current LSBs
    logic a_bit_c, b_bit_c, d_c, br_c, last_c;
    assign a_bit_c = a_sh[0];
    assign b_bit_c = b_sh[0];
    assign d_c     = a_bit_c ^ b_bit_c ^ br;
    assign br_c    = (~a_bit_c & b_bit_c) | (~(a_bit_c ^ b_bit_c) & br);
    assign last_c  = (cnt == CW'(W - 1));

`ifdef SIXBITSUB_SIGNED_EN
    logic ovf_q, ovf_n;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SIXBITSUB_SIGNED_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            a_sh  <= a_sh_n;
            b_sh  <= b_sh_n;
            r_sh  <= r_sh_n;
            br    <= br_n;
            cnt   <= cnt_n;
            diff  <= diff_n;
            bout  <= bout_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef SIXBITSUB_SIGNED_EN
            ovf_q <= ovf_n;
`endif
        end
    end

    // Next-state, datapath step and completion
    always_comb begin
        state_n = state;
        a_sh_n  = a_sh;
        b_sh_n  = b_sh;
        r_sh_n  = r_sh;
        br_n    = br;
        cnt_n   = cnt;
        diff_n  = diff;
        bout_n  = bout;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef SIXBITSUB_SIGNED_EN
        ovf_n   = ovf_q;
`endif

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_n  = ain;
                    b_sh_n  = bin;
                    r_sh_n  = '0;
                    br_n    = 1'b0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = S_RUN;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RUN: begin
                r_sh_n = {d_c, r_sh[W-1:1]};
                a_sh_n = a_sh >> 1;
                b_sh_n = b_sh >> 1;
                br_n   = br_c;
                cnt_n  = cnt + CW'(1);
                if (last_c) begin
                    diff_n  = {d_c, r_sh[W-1:1]};
                    bout_n  = br_c;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
`ifdef SIXBITSUB_SIGNED_EN
                    // On the last step the LSBs are the operands' sign bits
                    ovf_n = (a_bit_c != b_bit_c) && (d_c != a_bit_c);
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
